ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly upstream of the data-memory stage.
- Latches ALU result, store data, instruction and PC into the EX/MEM boundary registers.
- Contains a multi-cycle multiply/divide unit with HI/LO registers.
- Raises a stall to the front end while a HI/LO access conflicts with a busy multiply/divide.

---
 rtl/ex_stage.sv | 112 +++++++++++
 tb/tb_ex_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with EX/MEM registers and a multi-cycle mul/div unit.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   EX_pc, EX_instr           PC and instruction currently in EX (0 = nop)
//   EX_rs_data, EX_rt_data    forwarded rs/rt operands
//   ex_stall                  combinational hold request to the front end
//   MEM_pc, MEM_instr         registered PC/instruction to the memory stage
//   MEM_addr, MEM_data        registered ALU result and store data
module ex_stage #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_pc,
  input  logic [31:0] EX_instr,
  input  logic [31:0] EX_rs_data,
  input  logic [31:0] EX_rt_data,
  output logic        ex_stall,
  output logic [31:0] MEM_pc,
  output logic [31:0] MEM_instr,
  output logic [31:0] MEM_addr,
  output logic [31:0] MEM_data
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDIU = 6'h09,
                         OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  logic [31:0] r_hi, r_lo, r_phi, r_plo;
  logic [3:0]  r_md_cnt;
  logic [5:0]  w_op, w_fn;
  logic        w_r, w_mult, w_multu, w_div, w_divu, w_mfhi, w_mflo, w_mthi, w_mtlo;
  logic        w_md, w_busy, w_start, w_go;
  logic [31:0] w_imm_s, w_imm_z, w_result, w_md_hi, w_md_lo, w_uq, w_ur;
  logic signed [63:0] w_smul;
  logic [63:0] w_umul;
  logic signed [32:0] w_sa, w_sb, w_sq, w_sr;
  logic        w_unused;
  assign w_op    = EX_instr[31:26];
  assign w_fn    = EX_instr[5:0];
  assign w_r     = (w_op == OP_RTYPE);
  assign w_mult  = w_r && (w_fn == FN_MULT);
  assign w_multu = w_r && (w_fn == FN_MULTU);
  assign w_div   = w_r && (w_fn == FN_DIV);
  assign w_divu  = w_r && (w_fn == FN_DIVU);
  assign w_mfhi  = w_r && (w_fn == FN_MFHI);
  assign w_mflo  = w_r && (w_fn == FN_MFLO);
  assign w_mthi  = w_r && (w_fn == FN_MTHI);
  assign w_mtlo  = w_r && (w_fn == FN_MTLO);
  assign w_md    = w_mult || w_multu || w_div || w_divu || w_mfhi || w_mflo || w_mthi || w_mtlo;
  assign w_busy  = (r_md_cnt != 4'd0);
  assign ex_stall = w_busy && w_md;
  assign w_go    = !ex_stall;
  assign w_start = w_go && (w_mult || w_multu || w_div || w_divu);
  assign w_imm_s = {{16{EX_instr[15]}}, EX_instr[15:0]};
  assign w_imm_z = {16'd0, EX_instr[15:0]};
  assign w_result =
    (w_r && w_fn == FN_ADDU) ? EX_rs_data + EX_rt_data :
    (w_r && w_fn == FN_SUBU) ? EX_rs_data - EX_rt_data :
    (w_r && w_fn == FN_AND)  ? EX_rs_data & EX_rt_data :
    (w_r && w_fn == FN_OR)   ? EX_rs_data | EX_rt_data :
    (w_r && w_fn == FN_SLT)  ? {31'd0, $signed(EX_rs_data) < $signed(EX_rt_data)} :
    (w_r && w_fn == FN_SLTU) ? {31'd0, EX_rs_data < EX_rt_data} :
    w_mfhi ? r_hi :
    w_mflo ? r_lo :
    (w_op == OP_ADDIU || w_op == OP_LW || w_op == OP_SW) ? EX_rs_data + w_imm_s :
    (w_op == OP_ORI) ? EX_rs_data | w_imm_z :
    (w_op == OP_LUI) ? {EX_instr[15:0], 16'd0} :
    (w_op == OP_JAL) ? EX_pc + 32'd8 :
    32'd0;
  assign w_smul = $signed({{32{EX_rs_data[31]}}, EX_rs_data}) * $signed({{32{EX_rt_data[31]}}, EX_rt_data});
  assign w_umul = {32'd0, EX_rs_data} * {32'd0, EX_rt_data};
  // 33-bit signed operands so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000
  assign w_sa = $signed({EX_rs_data[31], EX_rs_data});
  assign w_sb = $signed({EX_rt_data[31], EX_rt_data});
  assign w_sq = w_sa / w_sb;
  assign w_sr = w_sa % w_sb;
  assign w_uq = EX_rs_data / EX_rt_data;
  assign w_ur = EX_rs_data % EX_rt_data;
  // a zero divisor recommits the current HI/LO, which cannot change while busy
  assign w_md_hi = w_mult ? w_smul[63:32] : w_multu ? w_umul[63:32] :
                   (EX_rt_data == 32'd0) ? r_hi : w_div ? w_sr[31:0] : w_ur;
  assign w_md_lo = w_mult ? w_smul[31:0] : w_multu ? w_umul[31:0] :
                   (EX_rt_data == 32'd0) ? r_lo : w_div ? w_sq[31:0] : w_uq;
  assign w_unused = ^{EX_instr[25:16], w_sq[32], w_sr[32]};
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_pc    <= '0;
      MEM_instr <= '0;
      MEM_addr  <= '0;
      MEM_data  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_phi     <= '0;
      r_plo     <= '0;
      r_md_cnt  <= '0;
    end else begin
      MEM_pc    <= w_go ? EX_pc : 32'd0;
      MEM_instr <= w_go ? EX_instr : 32'd0;
      MEM_addr  <= w_go ? w_result : 32'd0;
      MEM_data  <= w_go ? EX_rt_data : 32'd0;
      r_md_cnt  <= w_start ? ((w_mult || w_multu) ? 4'(MULT_LAT) : 4'(DIV_LAT)) :
                   w_busy ? r_md_cnt - 4'd1 : r_md_cnt;
      r_phi     <= w_start ? w_md_hi : r_phi;
      r_plo     <= w_start ? w_md_lo : r_plo;
      r_hi      <= (r_md_cnt == 4'd1) ? r_phi : (w_go && w_mthi) ? EX_rs_data : r_hi;
      r_lo      <= (r_md_cnt == 4'd1) ? r_plo : (w_go && w_mtlo) ? EX_rs_data : r_lo;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] EX_pc = '0, EX_instr = '0, EX_rs_data = '0, EX_rt_data = '0;
  logic        ex_stall;
  logic [31:0] MEM_pc, MEM_instr, MEM_addr, MEM_data;
  int checks = 0;
  int errors = 0;
  ex_stage dut (
    .clk(clk), .rst(rst), .EX_pc(EX_pc), .EX_instr(EX_instr),
    .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .ex_stall(ex_stall),
    .MEM_pc(MEM_pc), .MEM_instr(MEM_instr), .MEM_addr(MEM_addr), .MEM_data(MEM_data)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] r_ins(input logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction
  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    EX_pc = pc;
    EX_instr = ins;
    EX_rs_data = rs;
    EX_rt_data = rt;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    drive(32'h1234, r_ins(6'h21), 32'd5, 32'd7);
    tick;
    tick;
    checks++;
    if ({MEM_pc, MEM_instr, MEM_addr, MEM_data} !== 128'd0) begin
      errors++;
      $display("FAIL reset_mem: got %h %h %h %h required all 0", MEM_pc, MEM_instr, MEM_addr, MEM_data);
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b required 0", ex_stall);
    end
    rst = 1'b0;
  endtask
  task automatic test_alu;
    logic [31:0] ins [15];
    logic [31:0] rs [15];
    logic [31:0] rt [15];
    logic [31:0] ex [15];
    logic [31:0] pc;
    ins = '{r_ins(6'h21), r_ins(6'h23), r_ins(6'h24), r_ins(6'h25), r_ins(6'h2A), r_ins(6'h2B),
            {6'h03, 26'h100}, i_ins(6'h04, 16'h0010), i_ins(6'h3F, 16'hFFFF), i_ins(6'h09, 16'hFFFF),
            i_ins(6'h23, 16'h0008), i_ins(6'h2B, 16'hFFFC), i_ins(6'h0F, 16'h1234),
            i_ins(6'h0D, 16'h5678), i_ins(6'h0D, 16'h8000)};
    rs  = '{32'd5, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd5,
            32'd9, 32'd10, 32'h1000, 32'h10, 32'hFFFF, 32'h12340000, 32'd0};
    rt  = '{32'd7, 32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'd1, 32'd1, 32'd2, 32'd5,
            32'd9, 32'd3, 32'hDEAD, 32'hBEEF, 32'd4, 32'd6, 32'd8};
    ex  = '{32'd12, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'd1, 32'd0, 32'h3020, 32'd0,
            32'd0, 32'd9, 32'h1008, 32'h0000000C, 32'h12340000, 32'h12345678, 32'h00008000};
    for (int i = 0; i < 15; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      drive(pc, ins[i], rs[i], rt[i]);
      checks++;
      if (ex_stall !== 1'b0) begin
        errors++;
        $display("FAIL alu_stall[%0d]: got %b required 0", i, ex_stall);
      end
      tick;
      checks++;
      if (MEM_addr !== ex[i]) begin
        errors++;
        $display("FAIL alu_addr[%0d]: got %h required %h", i, MEM_addr, ex[i]);
      end
      checks++;
      if ({MEM_pc, MEM_instr, MEM_data} !== {pc, ins[i], rt[i]}) begin
        errors++;
        $display("FAIL alu_pass[%0d]: got %h %h %h required %h %h %h", i, MEM_pc, MEM_instr, MEM_data, pc, ins[i], rt[i]);
      end
    end
  endtask
  task automatic test_mult;
    int n;
    drive(32'h100, r_ins(6'h18), 32'hFFFFFFFE, 32'd3);
    tick;
    checks++;
    if (MEM_addr !== 32'd0 || MEM_instr !== r_ins(6'h18)) begin
      errors++;
      $display("FAIL mult_issue: got addr %h instr %h required 0 %h", MEM_addr, MEM_instr, r_ins(6'h18));
    end
    drive(32'h104, r_ins(6'h12), 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ex_stall !== 1'b1) begin
        errors++;
        $display("FAIL mult_stall[%0d]: got %b required 1", i, ex_stall);
      end
      tick;
      checks++;
      if (MEM_instr !== 32'd0) begin
        errors++;
        $display("FAIL mult_bubble[%0d]: got %h required 0", i, MEM_instr);
      end
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++;
      $display("FAIL mult_release: got %b required 0", ex_stall);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_lo: got %h required fffffffa", MEM_addr);
    end
    drive(32'h108, r_ins(6'h10), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mult_hi: got %h required ffffffff", MEM_addr);
    end
    drive(32'h10C, r_ins(6'h19), 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick;
    drive(32'h110, r_ins(6'h10), 32'd0, 32'd0);
    n = 0;
    while (ex_stall === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL multu_stalls: got %0d required 5", n);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_hi: got %h required fffffffe", MEM_addr);
    end
    drive(32'h114, r_ins(6'h12), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_lo: got %h required 00000001", MEM_addr);
    end
  endtask
  task automatic test_div;
    int n;
    drive(32'h200, r_ins(6'h1A), 32'hFFFFFFF9, 32'd2);
    tick;
    drive(32'h204, r_ins(6'h21), 32'd1, 32'd1);
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++;
      $display("FAIL div_addu_stall: got %b required 0", ex_stall);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'd2 || MEM_pc !== 32'h204) begin
      errors++;
      $display("FAIL div_addu: got addr %h pc %h required 2 204", MEM_addr, MEM_pc);
    end
    drive(32'h208, r_ins(6'h10), 32'd0, 32'd0);
    n = 0;
    while (ex_stall === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL div_stalls: got %0d required 9", n);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_hi: got %h required ffffffff", MEM_addr);
    end
    drive(32'h20C, r_ins(6'h12), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_lo: got %h required fffffffd", MEM_addr);
    end
    drive(32'h210, r_ins(6'h1A), 32'h80000000, 32'hFFFFFFFF);
    tick;
    drive(32'h214, r_ins(6'h12), 32'd0, 32'd0);
    n = 0;
    while (ex_stall === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL divovf_stalls: got %0d required 10", n);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'h80000000) begin
      errors++;
      $display("FAIL divovf_lo: got %h required 80000000", MEM_addr);
    end
    drive(32'h218, r_ins(6'h10), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'd0) begin
      errors++;
      $display("FAIL divovf_hi: got %h required 0", MEM_addr);
    end
  endtask
  task automatic test_div0;
    int n;
    drive(32'h300, r_ins(6'h11), 32'hAAAA, 32'd0);
    tick;
    drive(32'h304, r_ins(6'h13), 32'hBBBB, 32'd0);
    tick;
    drive(32'h308, r_ins(6'h1B), 32'd5, 32'd0);
    tick;
    drive(32'h30C, r_ins(6'h10), 32'd0, 32'd0);
    n = 0;
    while (ex_stall === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL div0_stalls: got %0d required 10", n);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'hAAAA) begin
      errors++;
      $display("FAIL div0_hi: got %h required 0000aaaa", MEM_addr);
    end
    drive(32'h310, r_ins(6'h12), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'hBBBB) begin
      errors++;
      $display("FAIL div0_lo: got %h required 0000bbbb", MEM_addr);
    end
    drive(32'h314, r_ins(6'h11), 32'h1111, 32'd0);
    tick;
    drive(32'h318, r_ins(6'h10), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'h1111) begin
      errors++;
      $display("FAIL mthi_back_to_back: got %h required 00001111", MEM_addr);
    end
  endtask
  task automatic test_reset_mid;
    drive(32'h400, r_ins(6'h1A), 32'd100, 32'd7);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(32'h404 + 32'(4 * i), 32'd0, 32'd0, 32'd0);
      tick;
    end
    drive(32'h410, r_ins(6'h10), 32'd1, 32'd2);
    checks++;
    if (ex_stall !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got %b required 1", ex_stall);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({MEM_pc, MEM_instr, MEM_addr, MEM_data} !== 128'd0) begin
      errors++;
      $display("FAIL rstmid_mem: got %h %h %h %h required all 0", MEM_pc, MEM_instr, MEM_addr, MEM_data);
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stall: got %b required 0", ex_stall);
    end
    tick;
    checks++;
    if (MEM_addr !== 32'd0 || MEM_instr !== r_ins(6'h10)) begin
      errors++;
      $display("FAIL rstmid_mfhi: got addr %h instr %h required 0 %h", MEM_addr, MEM_instr, r_ins(6'h10));
    end
    drive(32'h414, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) tick;
    drive(32'h418, r_ins(6'h12), 32'd0, 32'd0);
    tick;
    checks++;
    if (MEM_addr !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_discard: got %h required 0", MEM_addr);
    end
  endtask
  initial begin
    test_reset;
    test_alu;
    test_mult;
    test_div;
    test_div0;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
